pipeline_hazard_ctrl: RTL

Pipeline hazard/stall sequencer for the 5-stage core. It sits beside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve:
- load-use bubbles
- multi-cycle (mul/div) unit issue/wait handshake
- data-memory wait states
- taken-branch flushes
It drives the per-stage stall/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_mc_timer.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-control types and constants for the 5-stage core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1
    } hc_state_e;

    // Forward-select encodings shared with the EX-stage forwarding mux
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when a source operand is actually read and names the given rd
    function automatic logic rs_match(input logic       uses,
                                      input logic [4:0] rs,
                                      input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_mc_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag (multi-cycle timeout).
// Latency: count updates on the clock edge; tc is combinational from the count.
// Backpressure: none; clr has priority over load, load over en.
module hazard_mc_timer #(
    parameter int WIDTH  = 8,
    parameter int TC_VAL = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    // Count register: clear, then load, then increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == WIDTH'(TC_VAL));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for load-use, multi-cycle unit, dmem wait and taken-branch hazards.
// Latency: all stall/flush/mc_start outputs combinational from state and inputs (same cycle).
// Backpressure: dmem wait freezes every stage and suppresses flushes; optional HAZARD_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mc_op,
    input  logic        ex_branch_taken,
    input  logic        mc_done,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        mc_start,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        mc_busy,
    output logic        mc_timeout_err,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    hc_state_e            state_q, state_d;
    logic                 mc_held_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] tmr_cnt;
    logic                 tmr_tc;

    logic mem_wait, in_run, in_wait, rd_dep, load_use, mc_issue;
    logic wait_hold, mc_hold, ex_hold, br_flush, mc_finish, mc_timeout_hit;

    assign mem_wait       = dmem_req & ~dmem_ready;
    assign in_run         = (state_q == RUN);
    assign in_wait        = (state_q == MC_WAIT);
    assign rd_dep         = (ex_rd_addr != REG_X0) &&
                            (rs_match(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                             rs_match(id_uses_rs2, id_rs2_addr, ex_rd_addr));
    assign load_use       = in_run & ex_mem_read & rd_dep & ~mem_wait;
    // mc_held blocks a second launch of an op whose result is already back
    assign mc_issue       = in_run & ex_mc_op & ~mc_held_q & ~mem_wait;
    // The mc_done cycle releases the hold so the result moves on to MEM
    assign wait_hold      = in_wait & ~mc_done;
    assign mc_hold        = mc_issue | wait_hold;
    assign ex_hold        = mem_wait | mc_hold;
    // A branch is only acted on when EX actually advances
    assign br_flush       = ex_branch_taken & ~ex_hold;
    assign mc_finish      = in_wait & (mc_done | tmr_tc);
    assign mc_timeout_hit = in_wait & tmr_tc & ~mc_done;

    hazard_mc_timer #(
        .WIDTH  (CNT_WIDTH),
        .TC_VAL (MC_TIMEOUT - 1)
    ) u_mc_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~in_wait),
        .load     (1'b0),
        .load_val ('0),
        .en       (in_wait),
        .cnt      (tmr_cnt),
        .tc       (tmr_tc)
    );

    // State register plus result-held and sticky timeout flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mc_held_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!ex_hold) begin
                mc_held_q <= 1'b0;
            end else if (mc_finish) begin
                mc_held_q <= 1'b1;
            end
            if (mc_timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state: launch on issue, return on completion or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mc_issue)  state_d = MC_WAIT;
            MC_WAIT: if (mc_finish) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output decode, forced low while reset is asserted
    always_comb begin
        mc_start       = 1'b0;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        flush_mem      = 1'b0;
        mc_busy        = 1'b0;
        mc_timeout_err = 1'b0;
        if (rst_n) begin
            mc_start       = mc_issue;
            stall_if       = ex_hold | (load_use & ~br_flush);
            stall_id       = ex_hold | (load_use & ~br_flush);
            stall_ex       = ex_hold;
            stall_mem      = mem_wait;
            flush_id       = br_flush;
            flush_ex       = br_flush | (load_use & ~mc_hold);
            flush_mem      = mc_hold & ~mem_wait;
            mc_busy        = in_wait;
            mc_timeout_err = err_q;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    // Saturating stall-cycle and flush-event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_if && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_id && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_count  = 32'd0;
`endif

endmodule
